// File: rtl/softmax_exp_engine_if.sv
// Score stream, exponent stream, row-sum report and LUT programming port of the
// softmax exponent engine. The engine takes the slave side.
interface softmax_exp_engine_if #(
  parameter int DATA_W    = 8,
  parameter int VEC_LEN   = 16,
  parameter int LUT_DEPTH = 16,
  parameter int EXP_W     = 32,
  parameter int SUM_W     = EXP_W + $clog2(VEC_LEN)
);
  localparam int LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;

  logic                     lut_we;
  logic [LUT_AW-1:0]        lut_addr;
  logic [EXP_W-1:0]         lut_wdata;

  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W-1:0]         out_exp;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     out_sat;

  logic                     sum_valid;
  logic [SUM_W-1:0]         sum_exp;

  modport master (
    output in_valid, in_data, in_last, lut_we, lut_addr, lut_wdata, out_ready,
    input  in_ready, out_valid, out_exp, out_idx, out_last, out_sat, sum_valid, sum_exp
  );

  modport slave (
    input  in_valid, in_data, in_last, lut_we, lut_addr, lut_wdata, out_ready,
    output in_ready, out_valid, out_exp, out_idx, out_last, out_sat, sum_valid, sum_exp
  );
endinterface

// File: rtl/softmax_exp_engine.sv
// Buffers one row of signed scores while tracking the maximum, then streams
// LUT[min(max - x, LUT_DEPTH-1)] per element and reports the row sum.
module softmax_exp_engine #(
  parameter int DATA_W    = 8,
  parameter int VEC_LEN   = 16,
  parameter int LUT_DEPTH = 16,
  parameter int EXP_W     = 32,
  parameter int SUM_W     = EXP_W + $clog2(VEC_LEN)
) (
  input  logic clk,
  input  logic rst,
  softmax_exp_engine_if.slave io
);
  localparam int LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [DATA_W:0]   LUT_LIM   = (DATA_W+1)'(LUT_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {S_LOAD, S_EMIT, S_DONE} state_t;

  // Difference is never negative because max >= every buffered score.
  function automatic logic [DATA_W:0] row_diff(input logic signed [DATA_W-1:0] mx,
                                               input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] mx_e;
    logic signed [DATA_W:0] x_e;
    mx_e     = mx;
    x_e      = x;
    row_diff = mx_e - x_e;
  endfunction

  // Returns {saturated, lut_index}.
  function automatic logic [LUT_AW:0] clamp_index(input logic [DATA_W:0] d);
    if (d < LUT_LIM) clamp_index = {1'b0, d[LUT_AW-1:0]};
    else             clamp_index = {1'b1, LUT_AW'(LUT_DEPTH - 1)};
  endfunction

  state_t                   state;
  logic [IDX_W-1:0]         cnt;
  logic [IDX_W-1:0]         last_idx;
  logic signed [DATA_W-1:0] max_q;
  logic [SUM_W-1:0]         sum_q;
  logic signed [DATA_W-1:0] score_buf [VEC_LEN];
  logic [EXP_W-1:0]         lut_mem   [LUT_DEPTH];

  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [EXP_W-1:0]         out_exp_q;
  logic [IDX_W-1:0]         out_idx_q;
  logic                     out_last_q;
  logic                     out_sat_q;
  logic                     sum_valid_q;

  logic                     in_fire;
  logic                     row_close;
  logic                     emit_fire;
  logic                     at_last;
  logic [IDX_W-1:0]         nxt_idx;
  logic signed [DATA_W-1:0] max_nxt;
  logic signed [DATA_W-1:0] sel_max;
  logic signed [DATA_W-1:0] sel_score;
  logic [LUT_AW:0]          sat_idx;
  logic [EXP_W-1:0]         lut_rd;

  // Next-element select: element 0 while closing a row, element k+1 while emitting.
  // A LUT write landing on the same edge is forwarded so the registered output
  // shows what a read during its presentation cycle would return.
  always_comb begin
    in_fire   = io.in_valid && in_ready_q;
    row_close = io.in_last || (cnt == LAST_SLOT);
    emit_fire = out_valid_q && io.out_ready;
    at_last   = (out_idx_q == last_idx);
    nxt_idx   = out_idx_q + IDX_W'(1);
    max_nxt   = (cnt == '0 || io.in_data > max_q) ? io.in_data : max_q;
    if (state == S_LOAD) begin
      sel_max   = max_nxt;
      sel_score = (cnt == '0) ? io.in_data : score_buf[0];
    end else begin
      sel_max   = max_q;
      sel_score = score_buf[nxt_idx];
    end
    sat_idx = clamp_index(row_diff(sel_max, sel_score));
    lut_rd  = (io.lut_we && io.lut_addr == sat_idx[LUT_AW-1:0]) ? io.lut_wdata
                                                                : lut_mem[sat_idx[LUT_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst && in_fire) score_buf[cnt] <= io.in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_mem[i] <= '0;
    end else if (io.lut_we) begin
      lut_mem[io.lut_addr] <= io.lut_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_LOAD;
      cnt         <= '0;
      last_idx    <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_exp_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            max_q <= max_nxt;
            cnt   <= cnt + IDX_W'(1);
            if (row_close) begin
              state       <= S_EMIT;
              last_idx    <= cnt;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_idx_q   <= '0;
              out_last_q  <= (cnt == '0);
              out_sat_q   <= sat_idx[LUT_AW];
              out_exp_q   <= lut_rd;
            end
          end
        end
        S_EMIT: begin
          if (emit_fire) begin
            sum_q <= sum_q + SUM_W'(out_exp_q);
            if (at_last) begin
              state       <= S_DONE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_sat_q   <= 1'b0;
              sum_valid_q <= 1'b1;
            end else begin
              out_idx_q  <= nxt_idx;
              out_last_q <= (nxt_idx == last_idx);
              out_sat_q  <= sat_idx[LUT_AW];
              out_exp_q  <= lut_rd;
            end
          end
        end
        S_DONE: begin
          state       <= S_LOAD;
          cnt         <= '0;
          sum_q       <= '0;
          out_idx_q   <= '0;
          sum_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_exp   = out_exp_q;
  assign io.out_idx   = out_idx_q;
  assign io.out_last  = out_last_q;
  assign io.out_sat   = out_sat_q;
  assign io.sum_valid = sum_valid_q;
  assign io.sum_exp   = sum_q;
endmodule

// File: tb/tb_softmax_exp_engine.sv
// Scoreboard bench for softmax_exp_engine: expected exponents and sums are
// queued when a row is driven and compared as the engine produces them.
module tb_softmax_exp_engine;
  localparam int DATA_W    = 8;
  localparam int VEC_LEN   = 16;
  localparam int LUT_DEPTH = 16;
  localparam int EXP_W     = 32;
  localparam int SUM_W     = EXP_W + $clog2(VEC_LEN);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  softmax_exp_engine_if #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .LUT_DEPTH(LUT_DEPTH),
                          .EXP_W(EXP_W), .SUM_W(SUM_W)) sm ();

  softmax_exp_engine #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .LUT_DEPTH(LUT_DEPTH),
                       .EXP_W(EXP_W), .SUM_W(SUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (sm)
  );

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [3:0]       idx;
    logic             last;
    logic             sat;
  } exp_t;

  exp_t             sb_q [$];
  logic [SUM_W-1:0] sum_q [$];
  logic [EXP_W-1:0] lut_model [LUT_DEPTH];
  int               row [$];
  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               last_hs = -100;
  bit               stall_en = 0;
  int               pidx = 0;
  logic [5:0]       pat = 6'b101001;   // out_ready sequence 1,0,0,1,0,1 read from bit 0 up
  int               blk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int e, input int idx, input bit last, input bit sat);
    exp_t x;
    x.exp  = EXP_W'(e);
    x.idx  = 4'(idx);
    x.last = last;
    x.sat  = sat;
    sb_q.push_back(x);
  endtask

  // Reference model: max, clamped difference, LUT lookup, running sum.
  task automatic push_row();
    int mx;
    int d;
    logic [SUM_W-1:0] s;
    exp_t e;
    mx = row[0];
    foreach (row[i]) if (row[i] > mx) mx = row[i];
    s = '0;
    foreach (row[i]) begin
      d      = mx - row[i];
      e.sat  = (d >= LUT_DEPTH);
      e.exp  = lut_model[e.sat ? LUT_DEPTH-1 : d];
      e.idx  = 4'(i);
      e.last = (i == row.size() - 1);
      s      = s + SUM_W'(e.exp);
      sb_q.push_back(e);
    end
    sum_q.push_back(s);
  endtask

  task automatic load_lut(input int base, input int slope);
    for (int d = 0; d < LUT_DEPTH; d++) begin
      sm.lut_we    = 1'b1;
      sm.lut_addr  = 4'(d);
      sm.lut_wdata = EXP_W'(base + slope * d);
      lut_model[d] = EXP_W'(base + slope * d);
      @(posedge clk); #1;
    end
    sm.lut_we = 1'b0;
  endtask

  task automatic send_row(input bit use_last, input bit push, output int blocked);
    blocked = 0;
    if (push) push_row();
    foreach (row[i]) begin
      bit acc;
      int w;
      sm.in_valid = 1'b1;
      sm.in_data  = DATA_W'(row[i]);
      sm.in_last  = use_last && (i == row.size() - 1);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 100) begin
        @(negedge clk);
        acc = sm.in_ready;
        if (!acc) begin
          blocked++;
          w++;
        end
        @(posedge clk); #1;
      end
      if (!acc) check_eq("in_accept_timeout", {63'b0, acc}, 64'd1);
    end
    sm.in_valid = 1'b0;
    sm.in_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || sum_q.size() != 0) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("drain", 64'(sb_q.size() + sum_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"},  {63'b0, sm.in_ready},  64'd1);
    check_eq({tag, "_out_valid"}, {63'b0, sm.out_valid}, 64'd0);
    check_eq({tag, "_out_exp"},   64'(sm.out_exp),       64'd0);
    check_eq({tag, "_out_idx"},   64'(sm.out_idx),       64'd0);
    check_eq({tag, "_out_last"},  {63'b0, sm.out_last},  64'd0);
    check_eq({tag, "_out_sat"},   {63'b0, sm.out_sat},   64'd0);
    check_eq({tag, "_sum_valid"}, {63'b0, sm.sum_valid}, 64'd0);
    check_eq({tag, "_sum_exp"},   64'(sm.sum_exp),       64'd0);
  endtask

  initial begin
    sm.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_en) begin
        sm.out_ready = pat[pidx % 6];
        pidx++;
      end else begin
        sm.out_ready = 1'b1;
      end
    end
  end

  // Compare every presented element against the queue head; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst === 1'b1) begin
        if (sm.out_valid) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_out", {63'b0, sm.out_valid}, 64'd0);
          end else begin
            check_eq("out_exp",  64'(sm.out_exp),      64'(sb_q[0].exp));
            check_eq("out_idx",  64'(sm.out_idx),      64'(sb_q[0].idx));
            check_eq("out_last", {63'b0, sm.out_last}, {63'b0, sb_q[0].last});
            check_eq("out_sat",  {63'b0, sm.out_sat},  {63'b0, sb_q[0].sat});
            if (sm.out_ready) begin
              void'(sb_q.pop_front());
              last_hs = cyc;
            end
          end
        end
        if (sm.sum_valid) begin
          if (sum_q.size() == 0) begin
            check_eq("spurious_sum", {63'b0, sm.sum_valid}, 64'd0);
          end else begin
            check_eq("sum_exp", 64'(sm.sum_exp), 64'(sum_q.pop_front()));
            check_eq("sum_latency", 64'(cyc - last_hs), 64'd1);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    sm.in_valid = 1'b0;
    sm.in_data = '0;
    sm.in_last = 1'b0;
    sm.lut_we = 1'b0;
    sm.lut_addr = '0;
    sm.lut_wdata = '0;
    for (int d = 0; d < LUT_DEPTH; d++) lut_model[d] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;

    load_lut(100, -1);

    row = '{16, 0, -16, 8};
    send_row(1'b1, 1'b1, blk);
    drain();

    // Auto-close at VEC_LEN, then a single-score row held until the engine is back in LOAD.
    row = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    send_row(1'b0, 1'b1, blk);
    check_eq("full_row_blocked", 64'(blk), 64'd0);
    row = '{7};
    send_row(1'b1, 1'b1, blk);
    check_eq("row17_blocked", 64'(blk), 64'd17);
    drain();

    row = '{-128, -127};
    send_row(1'b1, 1'b1, blk);
    drain();
    row = '{-128, 127};
    send_row(1'b1, 1'b1, blk);
    drain();

    row = '{4, 1, -2, 3};
    send_row(1'b1, 1'b1, blk);
    drain();
    stall_en = 1'b1;
    pidx = 0;
    send_row(1'b1, 1'b1, blk);
    drain();
    stall_en = 1'b0;

    // LUT[0] rewritten while element 0 (d=0) is on the output.
    row = '{5, 2, 5};
    push_exp(100, 0, 1'b0, 1'b0);
    push_exp(97,  1, 1'b0, 1'b0);
    push_exp(500, 2, 1'b1, 1'b0);
    sum_q.push_back(SUM_W'(697));
    send_row(1'b1, 1'b0, blk);
    sm.lut_we = 1'b1;
    sm.lut_addr = '0;
    sm.lut_wdata = EXP_W'(500);
    lut_model[0] = EXP_W'(500);
    @(posedge clk); #1;
    sm.lut_we = 1'b0;
    drain();

    // Abort a row mid-EMIT.
    load_lut(100, -1);
    stall_en = 1'b1;
    pidx = 0;
    row = '{1, 2, 3, 4};
    send_row(1'b1, 1'b1, blk);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    sum_q.delete();
    for (int d = 0; d < LUT_DEPTH; d++) lut_model[d] = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    stall_en = 1'b0;
    @(negedge clk);
    check_idle("abort");
    @(posedge clk); #1;

    row = '{3};
    send_row(1'b1, 1'b1, blk);
    drain();
    load_lut(1000, 7);
    send_row(1'b1, 1'b1, blk);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
